// File: rtl/dcache_ctrl_if.sv
// Bus bundle for dcache_ctrl: CPU MEM-stage port and data-memory port.
//
// Handshake semantics:
//   CPU side: the pipeline raises cpu_ren or cpu_we with cpu_addr/cpu_din
//   and holds them unchanged while cpu_stall=1.  The access retires on the
//   first rising edge where cpu_stall=0.  Load data on cpu_dout is valid
//   in that same cycle.
//   Memory side: the controller raises mem_ren or mem_we from a register
//   and holds it, along with mem_addr and mem_dout, until it samples
//   mem_ack=1.  mem_ack is a one-cycle pulse, and mem_din is valid in
//   that same cycle.  The request drops on that edge, so at least one
//   request-free cycle follows every ack.
interface dcache_ctrl_if;
   logic        cpu_ren;
   logic        cpu_we;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_din;
   logic [31:0] cpu_dout;
   logic        cpu_stall;
   logic        mem_ren;
   logic        mem_we;
   logic        mem_cs;
   logic [31:0] mem_addr;
   logic [31:0] mem_dout;
   logic [31:0] mem_din;
   logic        mem_ack;

   // Cache controller side
   modport master (
      input  cpu_ren, cpu_we, cpu_addr, cpu_din,
      output cpu_dout, cpu_stall,
      output mem_ren, mem_we, mem_cs, mem_addr, mem_dout,
      input  mem_din, mem_ack
   );

   // Pipeline / memory side
   modport slave (
      output cpu_ren, cpu_we, cpu_addr, cpu_din,
      input  cpu_dout, cpu_stall,
      input  mem_ren, mem_we, mem_cs, mem_addr, mem_dout,
      output mem_din, mem_ack
   );
endinterface

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, one-word-per-line data cache.
// The cache is write-through and does not allocate on a write miss.
// Read hits add no cycles.  Misses and stores stall the CPU while a
// registered request to the multi-cycle memory is in flight.
// Optional macro DCACHE_STATS_EN adds the hit_cnt and miss_cnt counters.
module dcache_ctrl #(
   parameter int INDEX_WIDTH = 3,
   parameter int TAG_WIDTH   = 32 - INDEX_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   dcache_ctrl_if.master      bus,
   output logic [1:0]         state_dbg
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0]        hit_cnt,
   output logic [31:0]        miss_cnt
`endif
);

   localparam int LINES = 2 ** INDEX_WIDTH;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FILL  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                 state_q, state_d;

   logic [LINES-1:0]       valid_q;
   logic [TAG_WIDTH-1:0]   tag_q  [LINES];
   logic [31:0]            data_q [LINES];

   logic                   mem_ren_q, mem_we_q;
   logic [31:0]            mem_addr_q, mem_dout_q;

   logic [INDEX_WIDTH-1:0] cpu_idx, mem_idx;
   logic [TAG_WIDTH-1:0]   cpu_tag, mem_tag;
   logic                   hit, mem_line_hit;
   logic                   start_wr, start_rd, fill_done, write_done;
   logic                   stall;

   assign cpu_idx = bus.cpu_addr[INDEX_WIDTH-1:0];
   assign cpu_tag = bus.cpu_addr[31:INDEX_WIDTH];
   assign mem_idx = mem_addr_q[INDEX_WIDTH-1:0];
   assign mem_tag = mem_addr_q[31:INDEX_WIDTH];

   assign hit          = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
   assign mem_line_hit = valid_q[mem_idx] && (tag_q[mem_idx] == mem_tag);

   // Next-state and stall decode; a store takes priority over a load
   always_comb begin
      state_d    = state_q;
      stall      = 1'b0;
      start_wr   = 1'b0;
      start_rd   = 1'b0;
      fill_done  = 1'b0;
      write_done = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.cpu_we) begin
               state_d  = S_WRITE;
               stall    = 1'b1;
               start_wr = 1'b1;
            end else if (bus.cpu_ren && !hit) begin
               state_d  = S_FILL;
               stall    = 1'b1;
               start_rd = 1'b1;
            end
         end
         S_FILL: begin
            stall = 1'b1;
            if (bus.mem_ack) begin
               state_d   = S_IDLE;
               fill_done = !rst;
            end
         end
         S_WRITE: begin
            stall = 1'b1;
            if (bus.mem_ack) begin
               state_d    = S_DONE;
               write_done = !rst;
            end
         end
         S_DONE: begin
            // Retire the store for one cycle so the held cpu_we is not re-issued.
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State register and memory request registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         mem_ren_q  <= 1'b0;
         mem_we_q   <= 1'b0;
         mem_addr_q <= '0;
         mem_dout_q <= '0;
      end else begin
         state_q <= state_d;
         if (start_wr) begin
            mem_we_q   <= 1'b1;
            mem_addr_q <= bus.cpu_addr;
            mem_dout_q <= bus.cpu_din;
         end else if (start_rd) begin
            mem_ren_q  <= 1'b1;
            mem_addr_q <= bus.cpu_addr;
         end
         if (fill_done)  mem_ren_q <= 1'b0;
         if (write_done) mem_we_q  <= 1'b0;
      end
   end

   // Valid bits: cleared by reset, set by a completed fill
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
      end else if (fill_done) begin
         valid_q[mem_idx] <= 1'b1;
      end
   end

   // Tag/data arrays: a fill overwrites the line; a store updates the line only on a hit
   always_ff @(posedge clk) begin
      if (fill_done) begin
         data_q[mem_idx] <= bus.mem_din;
         tag_q[mem_idx]  <= mem_tag;
      end else if (write_done && mem_line_hit) begin
         data_q[mem_idx] <= mem_dout_q;
      end
   end

`ifdef DCACHE_STATS_EN
   // Hit/miss statistics counters, wrapping at 2**32
   always_ff @(posedge clk) begin
      if (rst) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else begin
         if (state_q == S_IDLE && bus.cpu_ren && hit && !bus.cpu_we) hit_cnt <= hit_cnt + 32'd1;
         if (start_rd) miss_cnt <= miss_cnt + 32'd1;
      end
   end
`else
   // Statistics counters are not built in this configuration.
`endif

   assign bus.cpu_stall = stall;
   assign bus.cpu_dout  = hit ? data_q[cpu_idx] : 32'd0;
   assign bus.mem_ren   = mem_ren_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_cs    = mem_ren_q | mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_dout  = mem_dout_q;
   assign state_dbg     = state_q;

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, one-word-per-line, write-through/no-write-allocate data cache between the pipeline MEM stage and the multi-cycle data memory.
- Memory side is a level-request/ack initiator: holds ren/we until ack, then drops the request.
- CPU side gets a combinational stall while a miss or write-through is in flight.
- Read hits complete in zero added cycles.

Parameters:
INDEX_WIDTH, 3, line index bits; 2**INDEX_WIDTH lines; word address index = cpu_addr[INDEX_WIDTH-1:0]
TAG_WIDTH, 32-INDEX_WIDTH, stored tag bits = cpu_addr[31:INDEX_WIDTH]

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  reset, synchronous, active-high
cpu_ren  input  1  load request, held by CPU while cpu_stall=1
cpu_we  input  1  store request, held by CPU while cpu_stall=1
cpu_addr  input  32  word address
cpu_din  input  32  store data
cpu_dout  output  32  load data, valid when cpu_ren=1 and cpu_stall=0
cpu_stall  output  1  combinational; freeze pipeline
mem_ren  output  1  memory read request (registered)
mem_we  output  1  memory write request (registered)
mem_cs  output  1  mem_ren | mem_we
mem_addr  output  32  registered request address
mem_dout  output  32  registered write data
mem_din  input  32  memory read data, sampled on the edge where mem_ack=1
mem_ack  input  1  one-cycle completion pulse from memory

Behaviour:
- Storage per line: valid, tag[TAG_WIDTH], data[32].
- hit = valid[idx] & (tag[idx] == cpu_addr[31:INDEX_WIDTH]).
- States: S_IDLE, S_FILL, S_WRITE, S_DONE.
- S_IDLE:
  - cpu_we=1 (priority over cpu_ren) -> S_WRITE; latch mem_addr=cpu_addr, mem_dout=cpu_din; mem_we=1.
  - else cpu_ren=1 & ~hit -> S_FILL; latch mem_addr=cpu_addr; mem_ren=1.
  - else stay.
- S_FILL:
  - Hold mem_ren, mem_addr until mem_ack sampled 1.
  - On that edge: data[idx]=mem_din, tag[idx]=mem_addr tag, valid[idx]=1; mem_ren=0; -> S_IDLE.
  - The request now hits in S_IDLE the following cycle with stall=0.
- S_WRITE:
  - Hold mem_we, mem_addr, mem_dout until mem_ack sampled 1.
  - On that edge: if the line at mem_addr index has a matching tag and is valid, data=mem_dout (update on hit); a miss does not allocate. mem_we=0; -> S_DONE.
- S_DONE: one cycle, cpu_stall=0, no memory request; -> S_IDLE. Retires the store so the held cpu_we is not re-issued.
- cpu_stall:
  - S_IDLE: (cpu_we) | (cpu_ren & ~hit).
  - S_FILL/S_WRITE: 1.
  - S_DONE: 0.
- cpu_dout = data[idx] when hit, else 0.
- Memory requests are only asserted from a registered state; at least one request-free cycle always follows each mem_ack.
- Latency: read hit 0 extra cycles; read miss = memory latency + 1 (IDLE re-lookup); store = memory latency + 1 (S_DONE).
- Reset (any state, including mid-fill/write): state=S_IDLE, all valid=0, mem_ren=mem_we=0, mem_addr=0, mem_dout=0, cpu_stall follows S_IDLE rule. An in-flight ack arriving after reset is ignored.
- mem_ack while in S_IDLE/S_DONE: ignored.
- Address wrap: index uses low bits only; lines with the same index and a different tag evict on fill.

Optional Feature:
DCACHE_STATS_EN
- Defined: adds outputs hit_cnt[31:0] and miss_cnt[31:0], reset to 0.
  - hit_cnt increments on every S_IDLE cycle with cpu_ren=1, hit=1, cpu_we=0.
  - miss_cnt increments on each S_IDLE -> S_FILL transition.
  - Counters wrap at 2**32.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Cold read of addr 0x5 (memory latency 9) -> cpu_stall=1, mem_ren=1 with mem_addr=0x5 until ack; stall drops the cycle after ack; cpu_dout=mem word 5; a second read of 0x5 gives stall=0 and no mem_ren.
- Write 0xDEADBEEF to cached 0x5 -> mem_we=1, mem_dout=0xDEADBEEF held until ack; one S_DONE cycle with stall=0; next read of 0x5 hits and returns 0xDEADBEEF.
- Write to uncached 0x6 -> write-through occurs; next read of 0x6 misses (no allocate).
- Conflict: read 0x5 then 0xD (INDEX_WIDTH=3) -> both miss; a re-read of 0x5 misses again (evicted).
- Simultaneous cpu_ren=1 and cpu_we=1 -> write path taken; mem_ren never asserted.
- rst asserted mid-S_FILL -> next cycle mem_ren=0, state S_IDLE; a subsequent read of the same address misses (valid cleared); a late ack is ignored.
